// File: rtl/fft_frame_ctrl.sv
// Frames a mono sample stream into FFT blocks and sequences a streaming FFT core.
// The input side builds sop/eop framing, latches the point count and bounds the number
// of frames in flight. The output side checks the returned framing and forwards bins.
module fft_frame_ctrl #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PTS_W        = 11,
  parameter int unsigned DEF_PTS      = 1024,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [PTS_W-1:0]  cfg_pts,
  input  logic              smp_valid,
  output logic              smp_ready,
  input  logic [DATA_W-1:0] smp_data,
  output logic              fft_sink_valid,
  input  logic              fft_sink_ready,
  output logic              fft_sink_sop,
  output logic              fft_sink_eop,
  output logic [DATA_W-1:0] fft_sink_real,
  output logic [DATA_W-1:0] fft_sink_imag,
  output logic [1:0]        fft_sink_error,
  output logic [PTS_W-1:0]  fft_pts_in,
  input  logic              fft_src_valid,
  output logic              fft_src_ready,
  input  logic              fft_src_sop,
  input  logic              fft_src_eop,
  input  logic [1:0]        fft_src_error,
  input  logic [DATA_W-1:0] fft_src_real,
  input  logic [DATA_W-1:0] fft_src_imag,
  input  logic [PTS_W-1:0]  fft_pts_out,
  output logic              bin_valid,
  input  logic              bin_ready,
  output logic [DATA_W-1:0] bin_real,
  output logic [DATA_W-1:0] bin_imag,
  output logic [PTS_W-1:0]  bin_idx,
  output logic              bin_last,
  output logic              frame_done,
  output logic              err_sticky,
  output logic              cfg_err
);

  localparam logic [PTS_W-1:0] DefPts   = PTS_W'(DEF_PTS);
  localparam logic [PTS_W-1:0] MinLegal = PTS_W'(8);
  localparam logic [PTS_W-1:0] MaxLegal = PTS_W'(1024);
  localparam logic [1:0]       MaxInf   = 2'(MAX_INFLIGHT);

  typedef enum logic {InIdle, InFeed} in_state_e;
  typedef enum logic [1:0] {OutWaitSop, OutRun, OutDrain} out_state_e;

  in_state_e        in_state_q;
  logic [PTS_W-1:0] pts_q;
  logic [PTS_W-1:0] in_cnt_q;
  logic             cfg_err_q;
  logic [1:0]       inflight_q;

  out_state_e       out_state_q;
  logic [PTS_W-1:0] out_pts_q;
  logic [PTS_W-1:0] out_cnt_q;
  logic             frame_done_q;
  logic             err_sticky_q;

  // Point-count FIFO: sized for the largest MAX_INFLIGHT, only MAX_INFLIGHT entries used.
  logic [PTS_W-1:0] fifo_q [4];
  logic [1:0]       wr_ptr_q;
  logic [1:0]       rd_ptr_q;
  logic [1:0]       fifo_cnt_q;

  logic             cfg_legal;
  logic [PTS_W-1:0] sel_pts;
  logic             feed;
  logic             in_last;
  logic             in_fire;
  logic             can_start;
  logic             back_to_back;

  logic             sop_start;
  logic             active;
  logic [PTS_W-1:0] cur_cnt;
  logic [PTS_W-1:0] cur_pts;
  logic             cur_last;
  logic             beat_err;
  logic             src_fire;
  logic             out_frame_end;
  logic             clean_end;

  logic             inc;
  logic             dec;
  logic             push_req;
  logic             pop_req;
  logic             do_push;
  logic             do_pop;
  logic             err_set;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == MaxInf - 2'd1) ? 2'd0 : p + 2'd1;
  endfunction

  // Input-side framing and acceptance, all combinational from the current state.
  always_comb begin
    cfg_legal    = (cfg_pts >= MinLegal) && (cfg_pts <= MaxLegal) &&
                   ((cfg_pts & (cfg_pts - PTS_W'(1))) == '0);
    sel_pts      = cfg_legal ? cfg_pts : DefPts;
    feed         = (in_state_q == InFeed);
    in_last      = (in_cnt_q == pts_q - PTS_W'(1));
    in_fire      = feed && smp_valid && fft_sink_ready;
    can_start    = (inflight_q < MaxInf);
    back_to_back = enable && (({1'b0, inflight_q} + 3'd1) < {1'b0, MaxInf});
  end

  assign fft_sink_valid = feed & smp_valid;
  assign smp_ready      = feed & fft_sink_ready;
  assign fft_sink_sop   = feed && (in_cnt_q == '0);
  assign fft_sink_eop   = feed & in_last;
  assign fft_sink_real  = feed ? smp_data : '0;
  assign fft_sink_imag  = '0;
  assign fft_sink_error = 2'b00;
  assign fft_pts_in     = pts_q;

  // Output-side beat classification; a sop beat in WaitSop is already bin 0 of the frame.
  always_comb begin
    sop_start     = (out_state_q == OutWaitSop) && fft_src_sop;
    active        = (out_state_q == OutRun) || sop_start;
    cur_cnt       = (out_state_q == OutRun) ? out_cnt_q : '0;
    cur_pts       = (out_state_q == OutRun) ? out_pts_q : fifo_q[rd_ptr_q];
    cur_last      = (cur_cnt == cur_pts - PTS_W'(1));
    // Early eop and missing eop both show up as eop disagreeing with the last index.
    beat_err      = active && fft_src_valid && ((fft_src_error != 2'b00) || (fft_src_eop != cur_last));
    fft_src_ready = active ? (beat_err | bin_ready) : 1'b1;
    src_fire      = fft_src_valid & fft_src_ready;
    out_frame_end = src_fire && fft_src_eop && (active || (out_state_q == OutDrain));
    clean_end     = src_fire && active && fft_src_eop && !beat_err;
  end

  assign bin_valid = active & fft_src_valid & ~beat_err;
  assign bin_real  = active ? fft_src_real : '0;
  assign bin_imag  = active ? fft_src_imag : '0;
  assign bin_idx   = active ? cur_cnt : '0;
  assign bin_last  = active & cur_last;

  // Bookkeeping requests and every error source feeding err_sticky.
  always_comb begin
    inc      = in_fire & fft_sink_eop;
    dec      = out_frame_end;
    push_req = in_fire & fft_sink_sop;
    pop_req  = src_fire & sop_start;
    do_pop   = pop_req && (fifo_cnt_q != 2'd0);
    do_push  = push_req && ((fifo_cnt_q < MaxInf) || do_pop);
    err_set  = (src_fire && (out_state_q == OutWaitSop) && !fft_src_sop) ||
               (src_fire && beat_err) ||
               (src_fire && active && (fft_pts_out != cur_pts)) ||
               (inc && !dec && (inflight_q == MaxInf)) ||
               (dec && !inc && (inflight_q == 2'd0)) ||
               (push_req && !do_push) || (pop_req && !do_pop);
  end

  // Input FSM: start frames while below the in-flight limit, latch the point count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_state_q <= InIdle;
      pts_q      <= DefPts;
      in_cnt_q   <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      unique case (in_state_q)
        InIdle: begin
          if (enable && can_start) begin
            pts_q      <= sel_pts;
            cfg_err_q  <= ~cfg_legal;
            in_cnt_q   <= '0;
            in_state_q <= InFeed;
          end
        end
        InFeed: begin
          if (in_fire) begin
            if (in_last) begin
              in_cnt_q <= '0;
              if (back_to_back) begin
                pts_q     <= sel_pts;
                cfg_err_q <= ~cfg_legal;
              end else begin
                in_state_q <= InIdle;
              end
            end else begin
              in_cnt_q <= in_cnt_q + PTS_W'(1);
            end
          end
        end
        default: in_state_q <= InIdle;
      endcase
    end
  end

  // Output FSM: track bin index, drop bad frames until eop, pulse frame_done on clean ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_state_q  <= OutWaitSop;
      out_pts_q    <= '0;
      out_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= clean_end;
      unique case (out_state_q)
        OutWaitSop, OutRun: begin
          if (src_fire && active) begin
            out_cnt_q <= cur_cnt + PTS_W'(1);
            if (sop_start) out_pts_q <= fifo_q[rd_ptr_q];
            if (fft_src_eop)   out_state_q <= OutWaitSop;
            else if (beat_err) out_state_q <= OutDrain;
            else               out_state_q <= OutRun;
          end
        end
        OutDrain: begin
          if (src_fire && fft_src_eop) out_state_q <= OutWaitSop;
        end
        default: out_state_q <= OutWaitSop;
      endcase
    end
  end

  // Point-count FIFO: written at input sop, read at output sop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        fifo_q[wr_ptr_q] <= pts_q;
        wr_ptr_q         <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      fifo_cnt_q <= fifo_cnt_q + 2'd1;
      else if (do_pop && !do_push) fifo_cnt_q <= fifo_cnt_q - 2'd1;
    end
  end

  // In-flight counter (saturating) and the sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q   <= 2'd0;
      err_sticky_q <= 1'b0;
    end else begin
      if (inc && !dec && (inflight_q != MaxInf))     inflight_q <= inflight_q + 2'd1;
      else if (dec && !inc && (inflight_q != 2'd0)) inflight_q <= inflight_q - 2'd1;
      err_sticky_q <= err_sticky_q | err_set;
    end
  end

  assign frame_done = frame_done_q;
  assign err_sticky = err_sticky_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: framing, illegal config, handshaking, in-flight limit,
// FFT error handling and mid-frame reset.
module tb_fft_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [10:0] cfg_pts;
  logic        smp_valid;
  logic        smp_ready;
  logic [31:0] smp_data;
  logic        fft_sink_valid;
  logic        fft_sink_ready;
  logic        fft_sink_sop;
  logic        fft_sink_eop;
  logic [31:0] fft_sink_real;
  logic [31:0] fft_sink_imag;
  logic [1:0]  fft_sink_error;
  logic [10:0] fft_pts_in;
  logic        fft_src_valid;
  logic        fft_src_ready;
  logic        fft_src_sop;
  logic        fft_src_eop;
  logic [1:0]  fft_src_error;
  logic [31:0] fft_src_real;
  logic [31:0] fft_src_imag;
  logic [10:0] fft_pts_out;
  logic        bin_valid;
  logic        bin_ready;
  logic [31:0] bin_real;
  logic [31:0] bin_imag;
  logic [10:0] bin_idx;
  logic        bin_last;
  logic        frame_done;
  logic        err_sticky;
  logic        cfg_err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_frame_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .cfg_pts        (cfg_pts),
    .smp_valid      (smp_valid),
    .smp_ready      (smp_ready),
    .smp_data       (smp_data),
    .fft_sink_valid (fft_sink_valid),
    .fft_sink_ready (fft_sink_ready),
    .fft_sink_sop   (fft_sink_sop),
    .fft_sink_eop   (fft_sink_eop),
    .fft_sink_real  (fft_sink_real),
    .fft_sink_imag  (fft_sink_imag),
    .fft_sink_error (fft_sink_error),
    .fft_pts_in     (fft_pts_in),
    .fft_src_valid  (fft_src_valid),
    .fft_src_ready  (fft_src_ready),
    .fft_src_sop    (fft_src_sop),
    .fft_src_eop    (fft_src_eop),
    .fft_src_error  (fft_src_error),
    .fft_src_real   (fft_src_real),
    .fft_src_imag   (fft_src_imag),
    .fft_pts_out    (fft_pts_out),
    .bin_valid      (bin_valid),
    .bin_ready      (bin_ready),
    .bin_real       (bin_real),
    .bin_imag       (bin_imag),
    .bin_idx        (bin_idx),
    .bin_last       (bin_last),
    .frame_done     (frame_done),
    .err_sticky     (err_sticky),
    .cfg_err        (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds n beats with valid/ready held high; DUT must already be in the feeding state.
  task automatic feed(input int n, input bit drop_en);
    for (int i = 0; i < n; i++) begin
      smp_data = 32'(100 + i);
      #1;
      chk("in_ready", {31'd0, smp_ready}, 32'd1);
      chk("in_sop", {31'd0, fft_sink_sop}, (i == 0) ? 32'd1 : 32'd0);
      chk("in_eop", {31'd0, fft_sink_eop}, (i == n - 1) ? 32'd1 : 32'd0);
      chk("in_real", fft_sink_real, 32'(100 + i));
      if (i == 0) begin
        chk("in_imag", fft_sink_imag, 32'd0);
        chk("in_err", {30'd0, fft_sink_error}, 32'd0);
        chk("in_pts", {21'd0, fft_pts_in}, 32'(n));
      end
      if (drop_en) enable = 1'b0;
      step();
    end
  endtask

  // Returns one n-point frame from the FFT; err_at >= 0 injects error code 1 at that bin.
  task automatic drive_out(input int n, input int err_at, input bit exp_done);
    bit exp_v;
    for (int j = 0; j < n; j++) begin
      fft_src_valid = 1'b1;
      fft_src_sop   = (j == 0);
      fft_src_eop   = (j == n - 1);
      fft_src_error = (j == err_at) ? 2'b01 : 2'b00;
      fft_src_real  = 32'(200 + j);
      fft_src_imag  = 32'(j);
      fft_pts_out   = 11'(n);
      bin_ready     = 1'b1;
      #1;
      exp_v = (err_at < 0) || (j < err_at);
      chk("out_valid", {31'd0, bin_valid}, {31'd0, exp_v});
      chk("out_ready", {31'd0, fft_src_ready}, 32'd1);
      if (exp_v) begin
        chk("out_idx", {21'd0, bin_idx}, 32'(j));
        chk("out_last", {31'd0, bin_last}, (j == n - 1) ? 32'd1 : 32'd0);
        chk("out_real", bin_real, 32'(200 + j));
      end
      step();
    end
    fft_src_valid = 1'b0;
    fft_src_sop   = 1'b0;
    fft_src_eop   = 1'b0;
    fft_src_error = 2'b00;
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int cyc;
    reset_n        = 1'b0;
    enable         = 1'b0;
    cfg_pts        = 11'd8;
    smp_valid      = 1'b0;
    smp_data       = '0;
    fft_sink_ready = 1'b0;
    fft_src_valid  = 1'b0;
    fft_src_sop    = 1'b0;
    fft_src_eop    = 1'b0;
    fft_src_error  = 2'b00;
    fft_src_real   = '0;
    fft_src_imag   = '0;
    fft_pts_out    = '0;
    bin_ready      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, smp_ready}, 32'd0);
    chk("rst_svalid", {31'd0, fft_sink_valid}, 32'd0);
    chk("rst_pts", {21'd0, fft_pts_in}, 32'd1024);
    chk("rst_bvalid", {31'd0, bin_valid}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, err_sticky}, 32'd0);
    chk("rst_cfgerr", {31'd0, cfg_err}, 32'd0);
    reset_n = 1'b1;
    step();

    // Basic 8-point frame; enable drops mid-frame without cutting it short
    cfg_pts = 11'd8; enable = 1'b1; smp_valid = 1'b1; fft_sink_ready = 1'b1;
    step();
    chk("t2_cfgerr", {31'd0, cfg_err}, 32'd0);
    feed(8, 1'b1);
    chk("t2_idle", {31'd0, smp_ready}, 32'd0);
    drive_out(8, -1, 1'b1);
    step();
    chk("t2_done_pulse", {31'd0, frame_done}, 32'd0);
    chk("t2_err", {31'd0, err_sticky}, 32'd0);

    // Illegal cfg_pts falls back to 1024 points
    cfg_pts = 11'd100; enable = 1'b1; smp_valid = 1'b0;
    step();
    chk("t3_cfgerr", {31'd0, cfg_err}, 32'd1);
    chk("t3_pts", {21'd0, fft_pts_in}, 32'd1024);
    enable = 1'b0;
    step();
    chk("t3_cfgerr_clr", {31'd0, cfg_err}, 32'd0);
    smp_valid = 1'b1;
    feed(1024, 1'b0);
    drive_out(1024, -1, 1'b1);

    // Random valid against a toggling ready
    cfg_pts = 11'd8; enable = 1'b1; smp_valid = 1'b0;
    step();
    enable = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 200) begin
      fft_sink_ready = cyc[0];
      smp_valid      = 1'($urandom_range(0, 1));
      smp_data       = 32'(500 + acc);
      #1;
      chk("t4_valid", {31'd0, fft_sink_valid}, {31'd0, smp_valid});
      chk("t4_ready", {31'd0, smp_ready}, {31'd0, fft_sink_ready});
      if (smp_valid && fft_sink_ready) begin
        chk("t4_data", fft_sink_real, 32'(500 + acc));
        chk("t4_sop", {31'd0, fft_sink_sop}, (acc == 0) ? 32'd1 : 32'd0);
        chk("t4_eop", {31'd0, fft_sink_eop}, (acc == 7) ? 32'd1 : 32'd0);
        acc++;
      end
      step();
      cyc++;
    end
    chk("t4_count", 32'(acc), 32'd8);
    smp_valid = 1'b1; fft_sink_ready = 1'b1;
    #1;
    chk("t4_idle", {31'd0, smp_ready}, 32'd0);

    // In-flight limit: second frame fills the window, third waits for a returned frame
    enable = 1'b1;
    step();
    feed(8, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("t5_blocked", {31'd0, smp_ready}, 32'd0);
      step();
    end
    chk("t5_no_err", {31'd0, err_sticky}, 32'd0);
    drive_out(8, -1, 1'b1);
    for (int k = 0; k < 10 && !smp_ready; k++) step();
    chk("t5_restart", {31'd0, smp_ready}, 32'd1);
    feed(8, 1'b1);

    // FFT error at bin 3, then the following frame comes through clean
    drive_out(8, 3, 1'b0);
    chk("t6_err", {31'd0, err_sticky}, 32'd1);
    drive_out(8, -1, 1'b1);

    // Reset during beat 4 of a frame
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t7_pre", {31'd0, smp_ready}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t7_ready", {31'd0, smp_ready}, 32'd0);
    chk("t7_svalid", {31'd0, fft_sink_valid}, 32'd0);
    chk("t7_sop", {31'd0, fft_sink_sop}, 32'd0);
    chk("t7_eop", {31'd0, fft_sink_eop}, 32'd0);
    chk("t7_err", {31'd0, err_sticky}, 32'd0);
    chk("t7_pts", {21'd0, fft_pts_in}, 32'd1024);
    chk("t7_bvalid", {31'd0, bin_valid}, 32'd0);
    step();
    reset_n = 1'b1;
    enable  = 1'b1;
    step();
    feed(8, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
